// File: rtl/adder_pkg.sv
// Shared definitions for the multicycle adder: FSM state encoding and
// elaboration-time width helpers.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >>> 1;
    end
    return r;
  endfunction

  // A one-slice adder still needs a one-bit counter register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into its top bit so the caller can derive overflow.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // Each cell owns its own carry nets so the chain is not one self-referencing vector.
  for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
    logic c_in_w;
    logic c_out_w;

    if (gi == 0) begin : g_first
      assign c_in_w = ci;
    end else begin : g_chain
      assign c_in_w = g_fa[gi-1].c_out_w;
    end

    assign s[gi]   = a[gi] ^ b[gi] ^ c_in_w;
    assign c_out_w = (a[gi] & b[gi]) | (c_in_w & (a[gi] ^ b[gi]));
  end

  assign co    = g_fa[SLICE-1].c_out_w;
  assign c_msb = g_fa[SLICE-1].c_in_w;

endmodule

// File: rtl/multicycle_adder.sv
// Sequential adder/subtractor: one SLICE-bit chunk per cycle through a registered
// carry, with valid/ready handshakes on both the operand and result sides.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SAFE_SLICE = (SLICE < 1) ? 1 : SLICE;
  localparam int N          = WIDTH / SAFE_SLICE;
  localparam int CW         = cnt_width(N);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SAFE_SLICE{1'b1}});

  if (SLICE < 1 || (WIDTH % SAFE_SLICE) != 0) begin : g_param_check
    $error("multicycle_adder: WIDTH must be a positive multiple of SLICE");
  end

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;

  logic [31:0]          base;
  logic [SAFE_SLICE-1:0] a_sl;
  logic [SAFE_SLICE-1:0] b_sl;
  logic [SAFE_SLICE-1:0] s_sl;
  logic                  co_sl;
  logic                  cmsb_sl;
  logic [WIDTH-1:0]      sum_next;

  // Slice k lives at bit offset k*SLICE in operands and result alike.
  always_comb begin
    base     = 32'(cnt_reg) * 32'(SAFE_SLICE);
    a_sl     = SAFE_SLICE'(a_reg >> base);
    b_sl     = SAFE_SLICE'(b_reg >> base);
    sum_next = (sum_reg & ~(SLICE_MASK << base)) | (WIDTH'(s_sl) << base);
  end

  adder_slice #(
    .SLICE(SAFE_SLICE)
  ) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .ci   (carry_reg),
    .s    (s_sl),
    .co   (co_sl),
    .c_msb(cmsb_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (in_valid && in_ready_reg) begin
            // Subtraction runs as A + ~B + ~borrow.
            a_reg        <= a;
            b_reg        <= b ^ {WIDTH{sub}};
            carry_reg    <= cin ^ sub;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= co_sl;
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(N - 1)) begin
            cout_reg      <= co_sl;
            ovf_reg       <= cmsb_sl ^ co_sl;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three instances (SLICE 4, 1, 16) checked against
// an integer-arithmetic reference model with directed and random operations.
module tb_multicycle_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          ci;
    bit          sb;
    logic [15:0] s;
    bit          co;
    bit          ov;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] a_s       [3];
  logic [15:0] b_s       [3];
  logic        cin_s     [3];
  logic        sub_s     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] sum_s     [3];
  logic        cout_s    [3];
  logic        ovf_s     [3];

  int n_cmp = 0;
  int n_bad = 0;
  int nlat [3] = '{4, 16, 1};

  vec_t dir_vecs [6] = '{
    '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0}
  };

  multicycle_adder #(.WIDTH(16), .SLICE(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum_s[0]), .cout(cout_s[0]), .ovf(ovf_s[0])
  );

  multicycle_adder #(.WIDTH(16), .SLICE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum_s[1]), .cout(cout_s[1]), .ovf(ovf_s[1])
  );

  multicycle_adder #(.WIDTH(16), .SLICE(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]), .sub(sub_s[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum_s[2]), .cout(cout_s[2]), .ovf(ovf_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input bit ci,
                           input bit sb, output logic [15:0] s, output bit co,
                           output bit ov);
    int ua, ub, sa, sbv, u, r;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (!sb) begin
      u  = ua + ub + int'(ci);
      co = (u >= 65536);
      r  = sa + sbv + int'(ci);
    end else begin
      u  = ua - ub - int'(ci);
      co = (ua >= ub + int'(ci));
      r  = sa - sbv - int'(ci);
    end
    s  = 16'(u);
    ov = (r > 32767) || (r < -32768);
  endtask

  task automatic start_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input bit ci, input bit sb);
    int t;
    @(negedge clk);
    t = 0;
    while (!in_ready[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check($sformatf("in_ready_timeout_d%0d", d), 32'(in_ready[d]), 32'd1);
    a_s[d]      = a;
    b_s[d]      = b;
    cin_s[d]    = ci;
    sub_s[d]    = sb;
    in_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int n);
    int lat;
    lat = 0;
    while (!out_valid[d] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency_d%0d", d), 32'(lat), 32'(n));
  endtask

  task automatic take_result(input int d, input int hold, output logic [15:0] s,
                             output bit co, output bit ov);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    s  = sum_s[d];
    co = cout_s[d];
    ov = ovf_s[d];
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    check($sformatf("out_valid_drop_d%0d", d), 32'(out_valid[d]), 32'd0);
  endtask

  task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                       input bit ci, input bit sb, input int hold,
                       output logic [15:0] gs, output bit gco, output bit gov);
    logic [15:0] es;
    bit          eco, eov;
    start_op(d, a, b, ci, sb);
    wait_done(d, nlat[d]);
    take_result(d, hold, gs, gco, gov);
    ref_model(a, b, ci, sb, es, eco, eov);
    check($sformatf("sum_d%0d", d), 32'(gs), 32'(es));
    check($sformatf("cout_d%0d", d), 32'(gco), 32'(eco));
    check($sformatf("ovf_d%0d", d), 32'(gov), 32'(eov));
    $display("op d=%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
             d, a, b, ci, sb, gs, gco, gov);
  endtask

  initial begin
    logic [15:0] gs;
    bit          gco, gov;
    logic [15:0] held;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      a_s[i]       = '0;
      b_s[i]       = '0;
      cin_s[i]     = 1'b0;
      sub_s[i]     = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_sum", 32'(sum_s[0]), 32'd0);
    check("rst_cout", 32'(cout_s[0]), 32'd0);
    check("rst_ovf", 32'(ovf_s[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("rst_in_ready_d%0d", i), 32'(in_ready[i]), 32'd1);

    // Directed vectors on every slice configuration.
    for (int d = 0; d < 3; d++) begin
      for (int v = 0; v < 6; v++) begin
        do_op(d, dir_vecs[v].a, dir_vecs[v].b, dir_vecs[v].ci, dir_vecs[v].sb, v % 3,
              gs, gco, gov);
        check($sformatf("dir%0d_sum_d%0d", v, d), 32'(gs), 32'(dir_vecs[v].s));
        check($sformatf("dir%0d_cout_d%0d", v, d), 32'(gco), 32'(dir_vecs[v].co));
        check($sformatf("dir%0d_ovf_d%0d", v, d), 32'(gov), 32'(dir_vecs[v].ov));
      end
    end

    // Backpressure: result must hold and a new request must be ignored.
    start_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(0, 4);
    held = sum_s[0];
    check("bp_first_sum", 32'(held), 32'h5555);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a_s[0]      = 16'hFFFF;
        b_s[0]      = 16'hFFFF;
        in_valid[0] = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      check("bp_out_valid", 32'(out_valid[0]), 32'd1);
      check("bp_sum", 32'(sum_s[0]), 32'h5555);
      check("bp_cout", 32'(cout_s[0]), 32'd0);
      check("bp_ovf", 32'(ovf_s[0]), 32'd0);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    take_result(0, 0, gs, gco, gov);
    check("bp_taken_sum", 32'(gs), 32'h5555);
    check("bp_idle_in_ready", 32'(in_ready[0]), 32'd1);
    $display("op d=0 backpressure hold sum=%h", gs);
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, gs, gco, gov);
    check("bp_next_sum", 32'(gs), 32'h0000);
    check("bp_next_cout", 32'(gco), 32'd1);

    // Abort during the second RUN cycle.
    start_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid[0]), 32'd0);
    check("abort_sum", 32'(sum_s[0]), 32'd0);
    $display("op d=0 aborted by reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 32'(in_ready[0]), 32'd1);
    do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, gs, gco, gov);
    check("abort_next_sum", 32'(gs), 32'h5555);

    // Random operations on the bit-serial and single-cycle configurations.
    for (int d = 1; d < 3; d++) begin
      for (int k = 0; k < 1000; k++) begin
        do_op(d, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), gs, gco, gov);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
